tspi_master: RTL and testbench

- Parametrised ternary SPI master. Shifts a TRITS-long balanced-ternary word out on O_mosi and samples the same number of trits from I_miso.
- Uses a ternary SCK: PLUS phase, then MINUS phase, ZERO when idle.
- Successor to the fixed single-trit link: programmable word length and clock divider, start/done handshake, optional transmit negation, and illegal-code detection.
- Sits between core logic and an off-chip ternary peripheral.

---
 rtl/tspi_pkg.sv | 33 +++
 rtl/tspi_master_phase_timer.sv | 37 +++
 rtl/tspi_master.sv | 143 ++++++++++++++
 tb/tb_tspi_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tspi_pkg.sv
// Shared ternary definitions for the ternary SPI master.
//   trit_t         : 2-bit balanced-ternary trit (ZERO=00, PLUS=01, MINUS=10, 11 illegal)
//   tspi_state_e   : transfer state machine encoding
//   neg3()         : trit-wise negation (PLUS<->MINUS, ZERO unchanged)
//   is_legal()     : 0 for the illegal code 2'b11
package tspi_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO  = 2'b00;
    localparam trit_t TRIT_PLUS  = 2'b01;
    localparam trit_t TRIT_MINUS = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_TRAIL,
        ST_DONE
    } tspi_state_e;

    function automatic trit_t neg3(input trit_t t);
        case (t)
            TRIT_PLUS:  return TRIT_MINUS;
            TRIT_MINUS: return TRIT_PLUS;
            default:    return t;
        endcase
    endfunction

    function automatic logic is_legal(input trit_t t);
        return (t != 2'b11);
    endfunction

endpackage

// File: rtl/tspi_master_phase_timer.sv
// Phase timer for the ternary SPI master.
// DIV-cycle down-counter shared by the LEAD and TRAIL phases.
//   I_clk  : system clock
//   I_rst  : synchronous active-high reset
//   I_load : restart the count at DIV-1 (transfer accepted)
//   I_en   : count this cycle (LEAD or TRAIL active)
//   O_last : high on the last cycle of the current phase
// The count reloads automatically when it reaches zero, so back-to-back
// phases need no extra load.
module tspi_phase_timer #(
    parameter int DIV = 2
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_load,
    input  logic I_en,
    output logic O_last
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            cnt <= '0;
        end else if (I_load) begin
            cnt <= RELOAD;
        end else if (I_en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
        end
    end

    assign O_last = I_en && (cnt == '0);

endmodule

// File: rtl/tspi_master.sv
// Ternary SPI master.
// Shifts a TRITS-long balanced-ternary word out on O_mosi (trit TRITS-1
// first) and samples as many trits from I_miso, using a ternary SCK
// (PLUS phase, then MINUS phase, ZERO when idle).
//   I_clk, I_rst : clock, synchronous active-high reset
//   I_start      : transfer request, accepted only in IDLE
//   I_tx, I_neg  : word to send and optional trit-wise negation, latched at start
//   O_busy       : high during LEAD/TRAIL
//   O_done       : one-cycle pulse, O_rx/O_err valid from this cycle
//   O_rx, O_err  : received word and illegal-code flag of the last transfer
//   O_mosi, O_sck, I_miso : ternary serial interface
module tspi_master
    import tspi_pkg::*;
#(
    parameter int TRITS = 6,
    parameter int DIV   = 2
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_start,
    input  logic [2*TRITS-1:0] I_tx,
    input  logic               I_neg,
    output logic               O_busy,
    output logic               O_done,
    output logic [2*TRITS-1:0] O_rx,
    output logic               O_err,
    output logic [1:0]         O_mosi,
    output logic [1:0]         O_sck,
    input  logic [1:0]         I_miso
);

    localparam int TW = (TRITS > 1) ? $clog2(TRITS) : 1;
    localparam logic [TW-1:0] TOP_IDX = TW'(TRITS - 1);

    tspi_state_e         state;
    trit_t [TRITS-1:0]   tx_word;
    trit_t [TRITS-1:0]   tx_in;
    logic [TW-1:0]       idx;
    logic [2*TRITS-1:0]  rx_sr;
    logic [2*TRITS-1:0]  rx_next;
    logic                err_flag;
    trit_t               miso_s;
    logic                phase_last;
    logic                timer_load;
    logic                timer_en;

    assign timer_load = (state == ST_IDLE) && I_start;
    assign timer_en   = (state == ST_LEAD) || (state == ST_TRAIL);

    tspi_phase_timer #(
        .DIV(DIV)
    ) u_timer (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_load (timer_load),
        .I_en   (timer_en),
        .O_last (phase_last)
    );

    // Word to latch at acceptance, already negated when requested.
    always_comb begin
        tx_in = '0;
        for (int unsigned k = 0; k < TRITS; k++) begin
            tx_in[k] = I_neg ? neg3(trit_t'(I_tx[2*k +: 2])) : trit_t'(I_tx[2*k +: 2]);
        end
    end

    // Illegal codes enter the rx word as ZERO; the error is tracked separately.
    always_comb begin
        miso_s       = is_legal(I_miso) ? I_miso : TRIT_ZERO;
        rx_next      = rx_sr << 2;
        rx_next[1:0] = miso_s;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= ST_IDLE;
            tx_word  <= '0;
            idx      <= '0;
            rx_sr    <= '0;
            err_flag <= 1'b0;
            O_busy   <= 1'b0;
            O_done   <= 1'b0;
            O_rx     <= '0;
            O_err    <= 1'b0;
            O_mosi   <= TRIT_ZERO;
            O_sck    <= TRIT_ZERO;
        end else begin
            case (state)
                ST_IDLE: begin
                    O_done <= 1'b0;
                    if (I_start) begin
                        tx_word  <= tx_in;
                        err_flag <= 1'b0;
                        rx_sr    <= '0;
                        idx      <= TOP_IDX;
                        O_mosi   <= tx_in[TRITS-1];
                        O_sck    <= TRIT_PLUS;
                        O_busy   <= 1'b1;
                        state    <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (phase_last) begin
                        rx_sr <= rx_next;
                        if (!is_legal(I_miso)) begin
                            err_flag <= 1'b1;
                        end
                        O_sck <= TRIT_MINUS;
                        state <= ST_TRAIL;
                    end
                end
                ST_TRAIL: begin
                    if (phase_last) begin
                        if (idx != '0) begin
                            idx    <= idx - 1'b1;
                            O_mosi <= tx_word[idx - 1'b1];
                            O_sck  <= TRIT_PLUS;
                            state  <= ST_LEAD;
                        end else begin
                            // Results are loaded on entry so they are valid with O_done.
                            O_rx   <= rx_sr;
                            O_err  <= err_flag;
                            O_done <= 1'b1;
                            O_busy <= 1'b0;
                            O_sck  <= TRIT_ZERO;
                            O_mosi <= TRIT_ZERO;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    O_done <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tspi_master.sv
// Self-checking bench for tspi_master: scoreboard of expected transfer
// results checked by an O_done monitor, plus directed waveform checks and
// a small TRITS=1/DIV=1 instance.
module tb_tspi_master;

    localparam int TRITS = 6;
    localparam int DIV   = 2;
    localparam int LAT   = 2*DIV*TRITS + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              neg = 1'b0;
    logic [2*TRITS-1:0] tx = '0;
    logic [2*TRITS-1:0] rx;
    logic              busy, done, err;
    logic [1:0]        mosi, sck, miso;
    logic [1:0]        miso_drv = 2'b00;
    logic              loop_mode = 1'b1;

    logic              start1 = 1'b0;
    logic [1:0]        tx1 = 2'b01;
    logic [1:0]        rx1, mosi1, sck1;
    logic [1:0]        miso1 = 2'b10;
    logic              busy1, done1, err1;

    always #5 clk = ~clk;

    assign miso = loop_mode ? mosi : miso_drv;

    tspi_master #(.TRITS(TRITS), .DIV(DIV)) dut (
        .I_clk(clk), .I_rst(rst), .I_start(start), .I_tx(tx), .I_neg(neg),
        .O_busy(busy), .O_done(done), .O_rx(rx), .O_err(err),
        .O_mosi(mosi), .O_sck(sck), .I_miso(miso)
    );

    tspi_master #(.TRITS(1), .DIV(1)) dut1 (
        .I_clk(clk), .I_rst(rst), .I_start(start1), .I_tx(tx1), .I_neg(1'b0),
        .O_busy(busy1), .O_done(done1), .O_rx(rx1), .O_err(err1),
        .O_mosi(mosi1), .O_sck(sck1), .I_miso(miso1)
    );

    // cyc at a falling edge = index of the clock cycle currently in progress
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    typedef struct {
        logic [2*TRITS-1:0] rx;
        logic               err;
        int unsigned        t_done;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Reference model: the word actually sent, from the trit encoding rules.
    function automatic logic [2*TRITS-1:0] sent_word(input logic [2*TRITS-1:0] w, input logic n);
        logic [2*TRITS-1:0] r;
        logic [1:0] t;
        r = '0;
        for (int k = 0; k < TRITS; k++) begin
            t = w[2*k +: 2];
            if (n && t == 2'b01)      t = 2'b10;
            else if (n && t == 2'b10) t = 2'b01;
            r[2*k +: 2] = t;
        end
        return r;
    endfunction

    // Peripheral model: per-trit response indexed by trit position k.
    logic [1:0]  miso_k[TRITS];
    int unsigned sent_j = 0;
    logic [1:0]  sck_prev = 2'b00;

    always @(negedge clk) begin
        if (sck == 2'b01 && sck_prev != 2'b01 && sent_j < TRITS) begin
            miso_drv = miso_k[TRITS-1-sent_j];
            sent_j++;
        end
        sck_prev = sck;
    end

    function automatic logic [2*TRITS-1:0] miso_word();
        logic [2*TRITS-1:0] r;
        r = '0;
        for (int k = 0; k < TRITS; k++)
            r[2*k +: 2] = (miso_k[k] == 2'b11) ? 2'b00 : miso_k[k];
        return r;
    endfunction

    function automatic logic miso_bad();
        logic b;
        b = 1'b0;
        for (int k = 0; k < TRITS; k++)
            if (miso_k[k] == 2'b11) b = 1'b1;
        return b;
    endfunction

    // Monitor: every O_done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: got O_done=1 expected no transfer pending", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx", 32'(rx), 32'(e.rx));
                check("err", 32'(err), 32'(e.err));
                check("done_cycle", cyc, e.t_done);
                check("done_idle_outputs", {busy, sck, mosi}, 32'd0);
            end
        end
    end

    task automatic wait_until(input int unsigned c);
        int unsigned guard;
        guard = 0;
        while (cyc < c && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Called at a falling edge; start is high during cycle t. Returns at cycle t+1.
    task automatic launch(input logic [2*TRITS-1:0] w, input logic n, input logic lp,
                          input logic [2*TRITS-1:0] exp_rx, input logic exp_err,
                          output int unsigned t);
        exp_t e;
        tx = w;
        neg = n;
        loop_mode = lp;
        sent_j = 0;
        start = 1'b1;
        t = cyc;
        e.rx = exp_rx;
        e.err = exp_err;
        e.t_done = t + LAT;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        tx = 2*TRITS'($urandom);
        neg = ~n;
    endtask

    task automatic check_wave(input logic [2*TRITS-1:0] sent);
        for (int i = 0; i < 2*DIV*TRITS; i++) begin
            int j;
            j = i / (2*DIV);
            check("sck_wave", 32'(sck), ((i % (2*DIV)) < DIV) ? 32'd1 : 32'd2);
            check("mosi_wave", 32'(mosi), 32'(sent[2*(TRITS-1-j) +: 2]));
            @(negedge clk);
        end
    endtask

    function automatic logic [2*TRITS-1:0] rand_word();
        logic [2*TRITS-1:0] r;
        for (int k = 0; k < TRITS; k++) r[2*k +: 2] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    initial begin
        int unsigned t;
        int dc;
        logic [2*TRITS-1:0] w;
        logic n, lp;

        for (int k = 0; k < TRITS; k++) miso_k[k] = 2'b00;

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, sck, mosi}, 32'd0);
        check("reset_rx", 32'(rx), 32'd0);
        check("reset1_outputs", {busy1, done1, err1, sck1, mosi1, rx1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Loopback, plain and negated
        launch(12'b011000010010, 1'b0, 1'b1, 12'b011000010010, 1'b0, t);
        check_wave(12'b011000010010);
        wait_until(t + LAT + 1);
        launch(12'b011000010010, 1'b1, 1'b1, 12'b100100100001, 1'b0, t);
        check_wave(12'b100100100001);
        wait_until(t + LAT + 1);

        // Illegal code on trit 3, then a clean transfer clears the flag
        miso_k[3] = 2'b11;
        launch(rand_word(), 1'b0, 1'b0, '0, 1'b1, t);
        wait_until(t + LAT + 1);
        for (int k = 0; k < TRITS; k++) miso_k[k] = 2'($urandom_range(0, 2));
        launch(rand_word(), 1'b0, 1'b0, miso_word(), 1'b0, t);
        wait_until(t + LAT + 1);

        // Starts while busy and in DONE are ignored; start right after DONE is taken
        w = rand_word();
        launch(w, 1'b0, 1'b1, w, 1'b0, t);
        wait_until(t + 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t + LAT);
        check("done_at_t25", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored", 32'(busy), 32'd0);
        launch(12'b010101010101, 1'b0, 1'b1, 12'b010101010101, 1'b0, t);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_until(t + LAT + 1);

        // Reset mid-transfer: no O_done for the aborted transfer
        launch(rand_word(), 1'b0, 1'b1, '0, 1'b0, t);
        wait_until(t + 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check("abort_outputs", {busy, done, err, sck, mosi}, 32'd0);
        check("abort_rx", 32'(rx), 32'd0);
        dc = done_count;
        repeat (30) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(dc));

        // Randomized transfers against the reference model
        for (int r = 0; r < 20; r++) begin
            w = rand_word();
            n = 1'($urandom);
            lp = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < TRITS; k++)
                miso_k[k] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (lp) launch(w, n, 1'b1, sent_word(w, n), 1'b0, t);
            else    launch(w, n, 1'b0, miso_word(), miso_bad(), t);
            wait_until(t + LAT + 1 + $urandom_range(0, 3));
        end

        // TRITS=1, DIV=1 instance
        t = cyc;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("small_sck_plus", 32'(sck1), 32'd1);
        check("small_mosi", 32'(mosi1), 32'd1);
        @(negedge clk);
        check("small_sck_minus", 32'(sck1), 32'd2);
        check("small_no_early_done", 32'(done1), 32'd0);
        @(negedge clk);
        check("small_done_cycle", 32'(done1), 32'd1);
        check("small_rx", 32'(rx1), 32'd2);
        check("small_err", 32'(err1), 32'd0);

        wait_until(cyc + 5);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_done: got %0d pending transfers expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
